// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add multiply and
// restoring divide over WIDTH cycles, followed by a one-cycle sign-fixup/writeback state.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hi_rd,
  input  logic             lo_rd,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  // Working registers: partial remainder/product in r_whi, quotient/multiplier in r_wlo.
  logic [WIDTH-1:0]   r_whi;
  logic [WIDTH-1:0]   r_wlo;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_b_zero;

  logic               w_start_ok;
  logic               w_signed;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_shift;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_start_ok = (r_state == S_IDLE) && start && !flush;
  assign w_signed   = ~op[0];
  assign w_a_abs    = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_abs    = (w_signed && b[WIDTH-1]) ? -b : b;

  assign w_msum  = {1'b0, r_whi} + (r_wlo[0] ? {1'b0, r_opnd} : '0);
  assign w_shift = {r_whi, r_wlo[WIDTH-1]};
  assign w_qbit  = (w_shift >= {1'b0, r_opnd});
  assign w_diff  = w_shift[WIDTH-1:0] - r_opnd;

  assign w_prod     = {r_whi, r_wlo};
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;

  // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      w_fix_hi = r_neg_rem ? -r_whi : r_whi;
      // A zero divisor must leave the all-ones quotient untouched.
      w_fix_lo = (r_neg_res && !r_b_zero) ? -r_wlo : r_wlo;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_CALC;
      S_CALC:  if (flush) w_next = S_IDLE;
               else if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_whi     <= '0;
      r_wlo     <= '0;
      r_opnd    <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_b_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_cnt     <= CW'(WIDTH - 1);
            r_is_div  <= op[1];
            r_whi     <= '0;
            r_wlo     <= op[1] ? w_a_abs : w_b_abs;
            r_opnd    <= op[1] ? w_b_abs : w_a_abs;
            r_neg_res <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_rem <= w_signed && a[WIDTH-1];
            r_b_zero  <= (b == '0);
          end else if (!start) begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        S_CALC: begin
          if (!flush) begin
            if (r_is_div) begin
              r_whi <= w_qbit ? w_diff : w_shift[WIDTH-1:0];
              r_wlo <= {r_wlo[WIDTH-2:0], w_qbit};
            end else begin
              r_whi <= w_msum[WIDTH:1];
              r_wlo <= {w_msum[0], r_wlo[WIDTH-1:1]};
            end
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          if (!flush) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign stall = busy && (start || hi_rd || lo_rd || mthi || mtlo);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): directed corner cases plus
// randomized operations compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             hi_rd;
  logic             lo_rd;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  int n_checks;
  int n_errors;
  logic [WIDTH-1:0] m_hi;
  logic [WIDTH-1:0] m_lo;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hi_rd(hi_rd), .lo_rd(lo_rd),
    .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: results straight from the arithmetic definition of each operation.
  task automatic model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] eh, output logic [31:0] el);
    longint      ps;
    logic [63:0] pv;
    int          sa;
    int          sb;
    sa = $signed(av);
    sb = $signed(bv);
    case (o)
      2'b00: begin
        ps = longint'(sa) * longint'(sb);
        pv = ps;
        eh = pv[63:32];
        el = pv[31:0];
      end
      2'b01: begin
        pv = {32'b0, av} * {32'b0, bv};
        eh = pv[63:32];
        el = pv[31:0];
      end
      2'b10: begin
        if (bv == 0) begin
          el = '1; eh = av;
        end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000; eh = 0;
        end else begin
          el = sa / sb; eh = sa % sb;
        end
      end
      default: begin
        if (bv == 0) begin
          el = '1; eh = av;
        end else begin
          el = av / bv; eh = av % bv;
        end
      end
    endcase
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
    mthi = h; mtlo = l; wdata = d;
    @(posedge clk); #1;
    mthi = 0; mtlo = 0;
    if (h) m_hi = d;
    if (l) m_lo = d;
  endtask

  // Launch one operation (called just after a rising edge) and watch it for a bounded window.
  // Event indices count cycles after the accepting edge; -1 disables an event.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int lo_rd_at, input int start_at,
                        input int flush_at, input int rst_at, input int exp_busy,
                        input int exp_done, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int busy_cnt;
    int done_cnt;
    int done_at;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    op = o; a = av; b = bv; start = 1;
    @(posedge clk); #1;
    start = 0; mthi = 0; mtlo = 0;
    op = 2'($urandom_range(3)); a = $urandom; b = $urandom;
    for (int i = 0; i < WIDTH + 6; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      lo_rd = 0; flush = 0; start = 0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (i == 3) check({tag, "_stall_quiet"}, stall, 0);
      if (i == lo_rd_at) begin
        lo_rd = 1; #1;
        check({tag, "_stall_lo_rd"}, stall, 1);
      end
      if (i == start_at) begin
        start = 1; a = $urandom; b = $urandom;
      end
      if (i == flush_at) flush = 1;
      if (i == rst_at) begin
        rst = 0; #1;
        check({tag, "_rst_hi"}, hi, 0);
        check({tag, "_rst_lo"}, lo, 0);
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_done"}, done, 0);
        rst = 1;
      end
    end
    lo_rd = 0; flush = 0; start = 0;
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check({tag, "_done_count"}, done_cnt, exp_done);
    if (exp_done > 0) check({tag, "_done_at"}, done_at, WIDTH + 1);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                       input logic [31:0] bv);
    model(o, av, bv, m_hi, m_lo);
    run_op(tag, o, av, bv, -1, -1, -1, -1, WIDTH + 1, 1, m_hi, m_lo);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(3))
      0:       return corners[$urandom_range(4)];
      1:       return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0] ro;
    clk = 0; rst = 0; start = 0; op = 0; a = 0; b = 0;
    mthi = 0; mtlo = 0; wdata = 0; hi_rd = 0; lo_rd = 0; flush = 0;
    n_checks = 0; n_errors = 0; m_hi = 0; m_lo = 0;

    #12;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_stall", stall, 0);
    @(posedge clk); #1;
    rst = 1;

    hi_rd = 1; lo_rd = 1; #1;
    check("idle_stall", stall, 0);
    hi_rd = 0; lo_rd = 0;
    @(posedge clk); #1;

    mt_write(1, 0, 32'hAAAA_5555);
    check("mthi_hi", hi, 32'hAAAA_5555);
    check("mthi_lo_kept", lo, 0);
    mt_write(1, 1, 32'h1234_5678);
    check("mt_both_hi", hi, 32'h1234_5678);
    check("mt_both_lo", lo, 32'h1234_5678);
    check("mt_no_done", done, 0);

    do_op("mult_neg", 2'b00, -32'sd3, 32'sd7);
    check("mult_neg_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo_const", lo, 32'hFFFF_FFEB);
    do_op("divu_100_7", 2'b11, 32'd100, 32'd7);
    check("divu_lo_const", lo, 32'd14);
    check("divu_hi_const", hi, 32'd2);
    do_op("div_m7_2", 2'b10, -32'sd7, 32'sd2);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    check("div_hi_const", hi, 32'hFFFF_FFFF);
    do_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_const", lo, 32'h8000_0000);
    check("div_ovf_hi_const", hi, 32'h0);
    do_op("divu_by0", 2'b11, 32'd5, 32'd0);
    check("divu0_lo_const", lo, 32'hFFFF_FFFF);
    check("divu0_hi_const", hi, 32'd5);
    do_op("div_neg_by0", 2'b10, -32'sd9, 32'd0);

    // start and mthi together: the write must be dropped
    mthi = 1; wdata = 32'hDEAD_BEEF;
    do_op("start_wins", 2'b01, 32'd1000, 32'd3);

    model(2'b01, 32'h0001_0003, 32'h0002_0005, m_hi, m_lo);
    run_op("busy_reqs", 2'b01, 32'h0001_0003, 32'h0002_0005, 10, 12, -1, -1, WIDTH + 1, 1,
           m_hi, m_lo);

    mt_write(1, 0, 32'h0BAD_F00D);
    mt_write(0, 1, 32'hCAFE_0001);
    run_op("flush", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 20, -1, 21, 0, m_hi, m_lo);

    start = 1; flush = 1; op = 2'b01; a = 32'd4; b = 32'd4;
    @(posedge clk); #1;
    start = 0; flush = 0;
    check("flush_start_busy", busy, 0);
    @(posedge clk); #1;
    check("flush_start_lo", lo, m_lo);

    for (int n = 0; n < 30; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 2'($urandom_range(3));
      ra = pick();
      rb = pick();
      do_op($sformatf("rand%0d_op%0d", n, ro), ro, ra, rb);
    end

    run_op("rst_mid", 2'b10, $urandom, 32'd7, -1, -1, -1, 15, 16, 0, 32'h0, 32'h0);
    m_hi = 0; m_lo = 0;
    do_op("multu_after_rst", 2'b01, 32'd2, 32'd3);
    check("after_rst_lo_const", lo, 32'd6);
    check("after_rst_hi_const", hi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width; legal values are 8, 16, 32 and 64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, launches the operation selected by op.
REQ-005 The block SHALL have port op, input, 2, operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have ports a and b, input, WIDTH each: a is multiplicand/dividend, b is multiplier/divisor.
REQ-007 The block SHALL have ports mthi and mtlo, input, 1 each, which write wdata into HI/LO respectively.
REQ-008 The block SHALL have port wdata, input, WIDTH, data for mthi/mtlo.
REQ-009 The block SHALL have ports hi_rd and lo_rd, input, 1 each, asserted by ID while mfhi/mflo is decoded.
REQ-010 The block SHALL have port flush, input, 1, which aborts an in-flight operation.
REQ-011 The block SHALL have ports hi and lo, output, WIDTH each, registered HI/LO.
REQ-012 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-013 The block SHALL have port done, output, 1, a one-cycle registered completion pulse.
REQ-014 The block SHALL have port stall, output, 1, combinational request to freeze PC/IF_ID/ID.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and FIX; a start accepted in IDLE SHALL move to CALC at that edge (edge k).
REQ-016 CALC SHALL last exactly WIDTH cycles, one radix-2 step per cycle: shift-add for multiply, restoring subtract for divide; an internal counter SHALL be loaded with WIDTH-1 and decremented to 0.
REQ-017 FIX SHALL last one cycle and apply sign correction for signed ops, write HI/LO, and return to IDLE; done SHALL be 1 for exactly the cycle following edge k+WIDTH+1.
REQ-018 Operands SHALL be captured at edge k; later changes on a/b/op SHALL NOT affect the result.
REQ-019 MULT/MULTU SHALL produce a 2*WIDTH-bit product with HI = upper half and LO = lower half; MULT SHALL treat operands as two's complement.
REQ-020 DIV/DIVU SHALL produce LO = quotient and HI = remainder; signed division SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-021 Divide by zero SHALL yield LO = all ones and HI = a, and SHALL still take the full latency.
REQ-022 Signed DIV of the most-negative value by -1 SHALL yield LO = most-negative value and HI = 0.
REQ-023 In IDLE, mthi/mtlo SHALL update HI/LO at the next edge; simultaneous mthi and mtlo SHALL write both.
REQ-024 start together with mthi/mtlo in IDLE: start SHALL win, and the write SHALL be discarded.
REQ-025 While busy, start, mthi and mtlo SHALL be ignored (no state change).
REQ-026 stall SHALL equal busy & (start | hi_rd | lo_rd | mthi | mtlo); stall SHALL be 0 in IDLE.
REQ-027 flush in CALC or FIX SHALL return the FSM to IDLE at the next edge, leave HI/LO unchanged and suppress done.
REQ-028 flush in IDLE SHALL have no effect; flush together with start in IDLE SHALL discard the start.
REQ-029 done SHALL NOT be asserted for mthi/mtlo writes.

Reset
REQ-030 rst low SHALL immediately force state IDLE, hi = 0, lo = 0, busy = 0, done = 0 and counter = 0, regardless of clk.
REQ-031 rst asserted mid-operation SHALL discard the operation; after release the block SHALL accept start on the first rising edge.

Verification (WIDTH = 32)
REQ-032 MULT a=-3, b=7 -> busy for 33 cycles, done once at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 DIVU a=100, b=7 -> lo=14, hi=2; DIV a=-7, b=2 -> lo=-3 (0xFFFFFFFD), hi=-1 (0xFFFFFFFF).
REQ-034 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
REQ-035 MULTU start, then lo_rd pulsed at cycle 10 -> stall=1 during that cycle; start at cycle 12 is ignored; the result is unchanged.
REQ-036 MULTU 0xFFFFFFFF*0xFFFFFFFF, flush at cycle 20 -> IDLE at the next edge, no done, HI/LO retain their previous mtlo/mthi values.
REQ-037 rst low at cycle 15 of DIV -> hi=lo=0 and busy=0 asynchronously; a new MULTU 2*3 after release -> lo=6, hi=0.
